// File: rtl/fp_d_issue_ctrl_pkg.sv
// Shared definitions for the double-precision FP issue controller: state encoding,
// opcodes and the request legality rule.
package fp_d_issue_ctrl_pkg;

    localparam int LAT_W = 3;

    localparam logic [1:0] OP_ADD_D = 2'b00;
    localparam logic [1:0] OP_SUB_D = 2'b01;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_A_LO,
        ST_RD_A_HI,
        ST_RD_B_LO,
        ST_RD_B_HI,
        ST_RD_LO,
        ST_RD_HI,
        ST_EXEC,
        ST_WR_LO,
        ST_WR_HI
    } state_t;

    // Pair bases must be even so that base+1 never wraps.
    function automatic logic req_legal(input logic [1:0] op, input logic fs0,
                                       input logic ft0, input logic fd0);
        return ((op == OP_ADD_D) || (op == OP_SUB_D)) && !fs0 && !ft0 && !fd0;
    endfunction

endpackage

// File: rtl/fp_d_exec_timer.sv
// ALU latency down-counter: loaded with LAT when EXEC is entered, expire is high
// on the last EXEC cycle.
module fp_d_exec_timer
    import fp_d_issue_ctrl_pkg::*;
#(
    parameter int unsigned LAT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);

    logic [LAT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LAT_W'(LAT);
        end else if (cnt != '0) begin
            cnt <= cnt - LAT_W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/fp_d_issue_ctrl.sv
// Operand supplier / result writer for the double-precision FP ALU: reads fs/ft register
// pairs, holds 64-bit operands for ALU_LAT+1 cycles, writes the result back to the fd pair.
// Define FP_D_DUAL_READ_EN to use a second read port (two read states instead of four).
module fp_d_issue_ctrl
    import fp_d_issue_ctrl_pkg::*;
#(
    parameter int unsigned ALU_LAT = 0,
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_op_i,
    input  logic [RADDR_W-1:0]    req_fs_i,
    input  logic [RADDR_W-1:0]    req_ft_i,
    input  logic [RADDR_W-1:0]    req_fd_i,
    output logic [RADDR_W-1:0]    rf_raddr_o,
    input  logic [WORD_W-1:0]     rf_rdata_i,
`ifdef FP_D_DUAL_READ_EN
    output logic [RADDR_W-1:0]    rf_raddr2_o,
    input  logic [WORD_W-1:0]     rf_rdata2_i,
`endif
    output logic                  rf_we_o,
    output logic [RADDR_W-1:0]    rf_waddr_o,
    output logic [WORD_W-1:0]     rf_wdata_o,
    output logic [2*WORD_W-1:0]   alu_a_o,
    output logic [2*WORD_W-1:0]   alu_b_o,
    output logic [1:0]            alu_ctrl_o,
    input  logic [2*WORD_W-1:0]   alu_result_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    state_t              state, state_nxt;
    logic                accept, legal, timer_load, timer_expire, err_q;
    logic [1:0]          op_q;
    logic [RADDR_W-1:0]  fs_q, ft_q, fd_q;
    logic [WORD_W-1:0]   a_lo, a_hi, b_lo, b_hi;
    logic [2*WORD_W-1:0] res_q;

    assign req_ready_o = (state == ST_IDLE);
    assign accept      = req_valid_i && req_ready_o;
    assign legal       = req_legal(req_op_i, req_fs_i[0], req_ft_i[0], req_fd_i[0]);

    fp_d_exec_timer #(.LAT(ALU_LAT)) u_timer (
        .clk    (clk_i),
        .rst_n  (rst_n_i),
        .load   (timer_load),
        .expire (timer_expire)
    );

    always_comb begin
        state_nxt  = state;
        rf_raddr_o = '0;
`ifdef FP_D_DUAL_READ_EN
        rf_raddr2_o = '0;
`endif
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        timer_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && legal) begin
`ifdef FP_D_DUAL_READ_EN
                    state_nxt = ST_RD_LO;
`else
                    state_nxt = ST_RD_A_LO;
`endif
                end
            end
`ifdef FP_D_DUAL_READ_EN
            ST_RD_LO: begin
                rf_raddr_o  = fs_q;
                rf_raddr2_o = ft_q;
                state_nxt   = ST_RD_HI;
            end
            ST_RD_HI: begin
                rf_raddr_o  = fs_q + RADDR_W'(1);
                rf_raddr2_o = ft_q + RADDR_W'(1);
                timer_load  = 1'b1;
                state_nxt   = ST_EXEC;
            end
`else
            ST_RD_A_LO: begin
                rf_raddr_o = fs_q;
                state_nxt  = ST_RD_A_HI;
            end
            ST_RD_A_HI: begin
                rf_raddr_o = fs_q + RADDR_W'(1);
                state_nxt  = ST_RD_B_LO;
            end
            ST_RD_B_LO: begin
                rf_raddr_o = ft_q;
                state_nxt  = ST_RD_B_HI;
            end
            ST_RD_B_HI: begin
                rf_raddr_o = ft_q + RADDR_W'(1);
                timer_load = 1'b1;
                state_nxt  = ST_EXEC;
            end
`endif
            ST_EXEC: begin
                if (timer_expire) state_nxt = ST_WR_LO;
            end
            ST_WR_LO: begin
                rf_we_o    = 1'b1;
                rf_waddr_o = fd_q;
                rf_wdata_o = res_q[WORD_W-1:0];
                state_nxt  = ST_WR_HI;
            end
            ST_WR_HI: begin
                rf_we_o    = 1'b1;
                rf_waddr_o = fd_q + RADDR_W'(1);
                rf_wdata_o = res_q[2*WORD_W-1:WORD_W];
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
            err_q <= 1'b0;
            op_q  <= '0;
            fs_q  <= '0;
            ft_q  <= '0;
            fd_q  <= '0;
            a_lo  <= '0;
            a_hi  <= '0;
            b_lo  <= '0;
            b_hi  <= '0;
            res_q <= '0;
        end else begin
            state <= state_nxt;
            err_q <= accept && !legal;
            if (accept) begin
                op_q <= req_op_i;
                fs_q <= req_fs_i;
                ft_q <= req_ft_i;
                fd_q <= req_fd_i;
            end
            // Read data is combinational, so each read state samples at its own end.
            case (state)
`ifdef FP_D_DUAL_READ_EN
                ST_RD_LO: begin
                    a_lo <= rf_rdata_i;
                    b_lo <= rf_rdata2_i;
                end
                ST_RD_HI: begin
                    a_hi <= rf_rdata_i;
                    b_hi <= rf_rdata2_i;
                end
`else
                ST_RD_A_LO: a_lo <= rf_rdata_i;
                ST_RD_A_HI: a_hi <= rf_rdata_i;
                ST_RD_B_LO: b_lo <= rf_rdata_i;
                ST_RD_B_HI: b_hi <= rf_rdata_i;
`endif
                ST_EXEC: if (timer_expire) res_q <= alu_result_i;
                default: ;
            endcase
        end
    end

    assign alu_a_o    = {a_hi, a_lo};
    assign alu_b_o    = {b_hi, b_lo};
    assign alu_ctrl_o = op_q;
    assign busy_o     = (state != ST_IDLE);
    assign done_o     = (state == ST_WR_HI);
    assign err_o      = err_q;

endmodule

// File: tb/tb_fp_d_issue_ctrl.sv
// Two controllers (ALU_LAT 0 and 3), each with a behavioural register file and FP ALU,
// driven by directed and random add.d/sub.d requests against a pair-level reference model.
module tb_fp_d_issue_ctrl;

    logic        clk;
    logic        rst_n      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [1:0]  req_op     [2];
    logic [4:0]  req_fs     [2];
    logic [4:0]  req_ft     [2];
    logic [4:0]  req_fd     [2];
    logic [4:0]  rf_raddr   [2];
    logic [31:0] rf_rdata   [2];
`ifdef FP_D_DUAL_READ_EN
    logic [4:0]  rf_raddr2  [2];
    logic [31:0] rf_rdata2  [2];
`endif
    logic        rf_we      [2];
    logic [4:0]  rf_waddr   [2];
    logic [31:0] rf_wdata   [2];
    logic [63:0] alu_a      [2];
    logic [63:0] alu_b      [2];
    logic [1:0]  alu_ctrl   [2];
    logic [63:0] alu_result [2];
    logic        busy       [2];
    logic        done       [2];
    logic        err        [2];

    logic [31:0] rf     [2][32];
    logic [31:0] ref_rf [2][32];
    int          wr_cnt   [2] = '{0, 0};
    int          done_cnt [2] = '{0, 0};
    int          checks = 0;
    int          errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] fp_alu(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] c);
        real ra, rb;
        ra = $bitstoreal(a);
        rb = $bitstoreal(b);
        return $realtobits((c == 2'b01) ? (ra - rb) : (ra + rb));
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        fp_d_issue_ctrl #(.ALU_LAT(g == 0 ? 0 : 3), .WORD_W(32), .RADDR_W(5)) u_dut (
            .clk_i        (clk),
            .rst_n_i      (rst_n[g]),
            .req_valid_i  (req_valid[g]),
            .req_ready_o  (req_ready[g]),
            .req_op_i     (req_op[g]),
            .req_fs_i     (req_fs[g]),
            .req_ft_i     (req_ft[g]),
            .req_fd_i     (req_fd[g]),
            .rf_raddr_o   (rf_raddr[g]),
            .rf_rdata_i   (rf_rdata[g]),
`ifdef FP_D_DUAL_READ_EN
            .rf_raddr2_o  (rf_raddr2[g]),
            .rf_rdata2_i  (rf_rdata2[g]),
`endif
            .rf_we_o      (rf_we[g]),
            .rf_waddr_o   (rf_waddr[g]),
            .rf_wdata_o   (rf_wdata[g]),
            .alu_a_o      (alu_a[g]),
            .alu_b_o      (alu_b[g]),
            .alu_ctrl_o   (alu_ctrl[g]),
            .alu_result_i (alu_result[g]),
            .busy_o       (busy[g]),
            .done_o       (done[g]),
            .err_o        (err[g])
        );
        assign rf_rdata[g]   = rf[g][rf_raddr[g]];
`ifdef FP_D_DUAL_READ_EN
        assign rf_rdata2[g]  = rf[g][rf_raddr2[g]];
`endif
        assign alu_result[g] = fp_alu(alu_a[g], alu_b[g], alu_ctrl[g]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rf_we[i]) begin
                rf[i][rf_waddr[i]] = rf_wdata[i];
                wr_cnt[i]++;
            end
            if (done[i]) done_cnt[i]++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_done_cycle(input int d);
`ifdef FP_D_DUAL_READ_EN
        return 5 + ((d == 0) ? 0 : 3);
`else
        return 7 + ((d == 0) ? 0 : 3);
`endif
    endfunction

    function automatic int rf_mismatches(input int d);
        int m = 0;
        for (int i = 0; i < 32; i++) if (rf[d][i] !== ref_rf[d][i]) m++;
        return m;
    endfunction

    task automatic set_pair(input int d, input int base, input logic [63:0] v);
        rf[d][base]       = v[31:0];
        rf[d][base+1]     = v[63:32];
        ref_rf[d][base]   = v[31:0];
        ref_rf[d][base+1] = v[63:32];
    endtask

    task automatic preload(input int d);
        real v;
        for (int p = 0; p < 16; p++) begin
            v = (real'($urandom_range(0, 2000)) - 1000.0) / 4.0;
            set_pair(d, 2 * p, $realtobits(v));
        end
        set_pair(d, 2, 64'h3FF00000_00000000);
        set_pair(d, 4, 64'h40000000_00000000);
    endtask

    task automatic chk_idle_zero(input int d, input string tag);
        chk({tag, "/we"},    64'(rf_we[d]),    64'd0);
        chk({tag, "/done"},  64'(done[d]),     64'd0);
        chk({tag, "/err"},   64'(err[d]),      64'd0);
        chk({tag, "/busy"},  64'(busy[d]),     64'd0);
        chk({tag, "/alu_a"}, alu_a[d],         64'd0);
        chk({tag, "/alu_b"}, alu_b[d],         64'd0);
        chk({tag, "/ctrl"},  64'(alu_ctrl[d]), 64'd0);
        chk({tag, "/raddr"}, 64'(rf_raddr[d]), 64'd0);
        chk({tag, "/waddr"}, 64'(rf_waddr[d]), 64'd0);
        chk({tag, "/wdata"}, 64'(rf_wdata[d]), 64'd0);
        chk({tag, "/ready"}, 64'(req_ready[d]), 64'd1);
    endtask

    task automatic do_op(input int d, input logic [1:0] op, input logic [4:0] fs,
                         input logic [4:0] ft, input logic [4:0] fd, input string tag);
        logic        legal;
        logic [63:0] ea, eb, er;
        logic [1:0]  hc [64];
        logic [63:0] ha [64];
        logic [63:0] hb [64];
        int          wc0, dc0, dk;
        legal = (op[1] == 1'b0) && !fs[0] && !ft[0] && !fd[0];
        ea = '0; eb = '0; er = '0;
        if (legal) begin
            ea = {ref_rf[d][int'(fs)+1], ref_rf[d][fs]};
            eb = {ref_rf[d][int'(ft)+1], ref_rf[d][ft]};
            er = $realtobits((op == 2'b01) ? ($bitstoreal(ea) - $bitstoreal(eb))
                                           : ($bitstoreal(ea) + $bitstoreal(eb)));
        end
        wc0 = wr_cnt[d];
        dc0 = done_cnt[d];
        @(negedge clk);
        chk({tag, "/ready_before"}, 64'(req_ready[d]), 64'd1);
        req_valid[d] = 1'b1;
        req_op[d] = op; req_fs[d] = fs; req_ft[d] = ft; req_fd[d] = fd;
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        if (!legal) begin
            @(negedge clk);
            chk({tag, "/err_pulse"}, 64'(err[d]), 64'd1);
            chk({tag, "/err_ready"}, 64'(req_ready[d]), 64'd1);
            chk({tag, "/err_busy"},  64'(busy[d]), 64'd0);
            @(negedge clk);
            chk({tag, "/err_one_cycle"}, 64'(err[d]), 64'd0);
            chk({tag, "/err_no_write"}, 64'(wr_cnt[d] - wc0), 64'd0);
            chk({tag, "/err_no_done"},  64'(done_cnt[d] - dc0), 64'd0);
        end else begin
            dk = 0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                hc[k] = alu_ctrl[d];
                ha[k] = alu_a[d];
                hb[k] = alu_b[d];
                if (done[d]) begin
                    dk = k;
                    break;
                end
            end
            chk({tag, "/done_cycle"}, 64'(dk), 64'(exp_done_cycle(d)));
            if (dk >= 3) begin
                chk({tag, "/exec_ctrl"}, 64'(hc[dk-2]), 64'(op));
                chk({tag, "/exec_a"}, ha[dk-2], ea);
                chk({tag, "/exec_b"}, hb[dk-2], eb);
            end
            @(negedge clk);
            chk({tag, "/ready_after"}, 64'(req_ready[d]), 64'd1);
            chk({tag, "/writes"}, 64'(wr_cnt[d] - wc0), 64'd2);
            chk({tag, "/done_pulses"}, 64'(done_cnt[d] - dc0), 64'd1);
            ref_rf[d][fd]         = er[31:0];
            ref_rf[d][int'(fd)+1] = er[63:32];
            chk({tag, "/rf_contents"}, 64'(rf_mismatches(d)), 64'd0);
        end
    endtask

    task automatic do_abort(input int d, input string tag);
        int wc0, dc0;
        wc0 = wr_cnt[d];
        dc0 = done_cnt[d];
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_op[d] = 2'b00; req_fs[d] = 5'd2; req_ft[d] = 5'd4; req_fd[d] = 5'd10;
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n[d] = 1'b0;
        #1 chk_idle_zero(d, {tag, "/in_reset"});
        @(negedge clk);
        rst_n[d] = 1'b1;
        @(negedge clk);
        chk({tag, "/ready"}, 64'(req_ready[d]), 64'd1);
        chk({tag, "/busy"},  64'(busy[d]), 64'd0);
        repeat (12) @(negedge clk);
        chk({tag, "/no_write"}, 64'(wr_cnt[d] - wc0), 64'd0);
        chk({tag, "/no_done"},  64'(done_cnt[d] - dc0), 64'd0);
        chk({tag, "/rf_kept"},  64'(rf_mismatches(d)), 64'd0);
    endtask

    task automatic random_ops(input int d, input int n);
        logic [1:0] op;
        logic [4:0] fs, ft, fd;
        for (int i = 0; i < n; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 2'(2 + $urandom_range(0, 1))
                                             : 2'($urandom_range(0, 1));
            fs = 5'(2 * $urandom_range(0, 15) + (($urandom_range(0, 9) == 0) ? 1 : 0));
            ft = 5'(2 * $urandom_range(0, 15) + (($urandom_range(0, 9) == 0) ? 1 : 0));
            fd = 5'(2 * $urandom_range(0, 15) + (($urandom_range(0, 9) == 0) ? 1 : 0));
            do_op(d, op, fs, ft, fd, $sformatf("rand%0d_%0d", d, i));
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            req_valid[d] = 1'b0;
            req_op[d] = '0; req_fs[d] = '0; req_ft[d] = '0; req_fd[d] = '0;
            preload(d);
        end
        #2;
        chk_idle_zero(0, "reset0");
        chk_idle_zero(1, "reset1");
        repeat (2) @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        do_op(0, 2'b00, 5'd2, 5'd4, 5'd6, "add_1p0_2p0");
        chk("add_f6", 64'(rf[0][6]), 64'h0000_0000);
        chk("add_f7", 64'(rf[0][7]), 64'h4008_0000);

        do_op(0, 2'b01, 5'd2, 5'd4, 5'd8, "sub_1p0_2p0");
        chk("sub_f8", 64'(rf[0][8]), 64'h0000_0000);
        chk("sub_f9", 64'(rf[0][9]), 64'hBFF0_0000);

        do_op(0, 2'b00, 5'd3, 5'd4, 5'd6, "odd_fs");
        do_op(0, 2'b10, 5'd2, 5'd4, 5'd6, "op_10");
        do_op(0, 2'b00, 5'd2, 5'd5, 5'd6, "odd_ft");
        do_op(0, 2'b01, 5'd2, 5'd4, 5'd7, "odd_fd");

        do_op(1, 2'b00, 5'd2, 5'd4, 5'd2, "lat3_overlap");
        chk("lat3_f2", 64'(rf[1][2]), 64'h0000_0000);
        chk("lat3_f3", 64'(rf[1][3]), 64'h4008_0000);

        do_op(0, 2'b01, 5'd30, 5'd28, 5'd30, "top_pair");

        random_ops(0, 16);
        random_ops(1, 12);

        do_abort(0, "abort0");
        do_abort(1, "abort1");
        do_op(0, 2'b00, 5'd4, 5'd4, 5'd12, "after_abort0");
        do_op(1, 2'b01, 5'd12, 5'd2, 5'd14, "after_abort1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
